ud_seq_arb: RTL and testbench

UD_SEQ_ARB -- requirements
Module: ud_seq_arb

---
 rtl/ud_seq_arb.sv | 146 ++++++++++++++
 tb/tb_ud_seq_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ud_seq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ud_seq_arb
//  Purpose  : Two-requester round-robin arbiter that walks a shared external
//             up/down counter to the granted requester's target value, one
//             step at a time, then pulses done for that requester.
//  Ports    : clk     - clock, rising edge
//             rst     - synchronous active-high reset
//             req     - [1:0] level requests, bit k = requester k
//             tgt0    - [W-1:0] target value for requester 0
//             tgt1    - [W-1:0] target value for requester 1
//             gnt     - [1:0] one-hot grant, high for the whole service
//             done    - [1:0] one-cycle pulse when the target is reached
//             cnt_q   - [W-1:0] current value of the shared counter
//             cnt_en  - counter step enable (one cycle per step)
//             cnt_up  - step direction, 1 = increment, 0 = decrement
//  Config   : UDS_SHORTEST_PATH_EN - when defined, steps in the direction of
//             the smaller modular distance (ties go up) and may wrap; when
//             undefined, steps up if target > cnt_q, down otherwise, no wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module ud_seq_arb #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] tgt0,
    input  logic [W-1:0] tgt1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_up
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]   r_state,  w_state_nx;
    logic         r_owner,  w_owner_nx;   // index of the requester being served
    logic         r_last,   w_last_nx;    // index of the most recently served requester
    logic [W-1:0] r_tgt,    w_tgt_nx;
    logic [1:0]   r_gnt,    w_gnt_nx;
    logic [1:0]   r_done,   w_done_nx;
    logic         r_cnt_en, w_cnt_en_nx;
    logic         r_cnt_up, w_cnt_up_nx;

    logic         w_pick;                 // arbitration winner for the current req
    logic         w_dir_up;               // direction of the next step from cnt_q

    // With both requesting, the one not served last wins; otherwise the sole
    // requester wins (req[1] is 1 only for the 2'b10 case here).
    assign w_pick = (req == 2'b11) ? ~r_last : req[1];

`ifdef UDS_SHORTEST_PATH_EN
    logic [W-1:0] w_dist_up;
    logic [W-1:0] w_dist_dn;

    // Modular distances; W-bit subtraction wraps naturally.
    assign w_dist_up = r_tgt - cnt_q;
    assign w_dist_dn = cnt_q - r_tgt;
    assign w_dir_up  = (w_dist_up <= w_dist_dn);
`else
    assign w_dir_up  = (r_tgt > cnt_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;     // makes requester 0 win the first contention
            r_tgt    <= '0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_cnt_en <= 1'b0;
            r_cnt_up <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_last   <= w_last_nx;
            r_tgt    <= w_tgt_nx;
            r_gnt    <= w_gnt_nx;
            r_done   <= w_done_nx;
            r_cnt_en <= w_cnt_en_nx;
            r_cnt_up <= w_cnt_up_nx;
        end
    end

    // Outputs are registered: each register is loaded with the value that
    // belongs to the state being entered.
    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_last_nx   = r_last;
        w_tgt_nx    = r_tgt;
        w_gnt_nx    = r_gnt;
        w_done_nx   = 2'b00;
        w_cnt_en_nx = 1'b0;
        w_cnt_up_nx = r_cnt_up;

        case (r_state)
            S_IDLE: begin
                w_gnt_nx = 2'b00;
                if (req != 2'b00) begin
                    w_owner_nx = w_pick;
                    w_tgt_nx   = w_pick ? tgt1 : tgt0;
                    w_gnt_nx   = w_pick ? 2'b10 : 2'b01;
                    w_state_nx = S_CMP;
                end
            end
            S_CMP: begin
                if (cnt_q == r_tgt) begin
                    w_done_nx  = r_owner ? 2'b10 : 2'b01;
                    w_state_nx = S_DONE;
                end else begin
                    w_cnt_up_nx = w_dir_up;
                    w_cnt_en_nx = 1'b1;
                    w_state_nx  = S_STEP;
                end
            end
            S_STEP: begin
                // Counter advances at the end of this cycle; re-compare next.
                w_state_nx = S_CMP;
            end
            S_DONE: begin
                w_last_nx  = r_owner;
                w_gnt_nx   = 2'b00;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_gnt_nx   = 2'b00;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign cnt_en = r_cnt_en;
    assign cnt_up = r_cnt_up;

endmodule
`default_nettype wire

// File: tb/tb_ud_seq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ud_seq_arb
//  Purpose  : Self-checking bench for ud_seq_arb. Models the shared counter,
//             predicts winner, step count, direction and done latency per
//             service from arithmetic on the targets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ud_seq_arb;

    localparam int W = 3;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] tgt0;
    logic [W-1:0] tgt1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [W-1:0] cnt_q;
    logic         cnt_en;
    logic         cnt_up;

    logic         load;
    logic [W-1:0] load_val;

    int n_checks = 0;
    int n_errors = 0;
    int last_win = 1;   // model of the round-robin history after reset

    ud_seq_arb #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .tgt0   (tgt0),
        .tgt1   (tgt1),
        .gnt    (gnt),
        .done   (done),
        .cnt_q  (cnt_q),
        .cnt_en (cnt_en),
        .cnt_up (cnt_up)
    );

    always #5 clk = ~clk;

    // Shared up/down counter driven by the DUT step interface.
    always @(posedge clk) begin
        if (load)
            cnt_q <= load_val;
        else if (cnt_en)
            cnt_q <= cnt_up ? cnt_q + W'(1) : cnt_q - W'(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Direction and number of steps from start value c to target t.
    function automatic void plan(input int c, input int t, output bit up, output int n);
`ifdef UDS_SHORTEST_PATH_EN
        int du;
        int dd;
        du = (t - c + M) % M;
        dd = (c - t + M) % M;
        up = (du <= dd);
        n  = up ? du : dd;
`else
        up = (t > c);
        n  = up ? (t - c) : (c - t);
`endif
    endfunction

    // One complete service: drive at cycle 0 (DUT idle), follow to done.
    task automatic txn(input logic [1:0] rq, input int t0, input int t1,
                       input int c0, input bit mid);
        int         win;
        int         t;
        int         n;
        int         dcyc;
        int         steps;
        int         gbad;
        int         dirbad;
        bit         up;
        logic [1:0] oh;

        @(negedge clk);
        check("idle_gnt", gnt, 0);
        req      = rq;
        tgt0     = W'(t0);
        tgt1     = W'(t1);
        load     = 1'b1;
        load_val = W'(c0);

        win = (rq == 2'b11) ? 1 - last_win : (rq[1] ? 1 : 0);
        t   = win ? t1 : t0;
        plan(c0, t, up, n);
        oh  = win ? 2'b10 : 2'b01;

        dcyc = -1; steps = 0; gbad = 0; dirbad = 0;
        for (int c = 1; c <= 2 * M + 8; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (gnt !== oh) gbad++;
            if (cnt_en === 1'b1) begin
                steps++;
                if (cnt_up !== up) dirbad++;
            end
            if (mid && c == 3) begin
                req  = 2'b00;
                tgt0 = ~tgt0;
                tgt1 = ~tgt1;
            end
            if (done !== 2'b00) begin
                dcyc = c;
                check("done_val", done, oh);
                check("final_cnt", cnt_q, t);
                break;
            end
        end
        check("done_cycle", dcyc, 2 * n + 2);
        check("steps", steps, n);
        check("gnt_hold", gbad, 0);
        check("direction", dirbad, 0);
        last_win = win;
    endtask

    // Reset asserted during a STEP cycle aborts the service with no done.
    task automatic reset_mid_step();
        bit seen;
        @(negedge clk);
        req      = 2'b01;
        tgt0     = W'(3);
        load     = 1'b1;
        load_val = W'(0);
        seen     = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (cnt_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_step_seen", seen, 1);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_en", cnt_en, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle", {gnt, done}, 0);
        end
        last_win = 1;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        tgt0     = '0;
        tgt1     = '0;
        load     = 1'b1;
        load_val = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_cnt_en", cnt_en, 0);
        check("rst_cnt_up", cnt_up, 0);
        rst  = 1'b0;
        load = 1'b0;

        reset_mid_step();

        // Contention straight after reset: 0, 1, 0, 1.
        txn(2'b11, 3, 6, 4, 1'b0);
        txn(2'b11, 1, 2, 3, 1'b0);
        txn(2'b11, 0, 0, 0, 1'b0);
        txn(2'b11, 7, 5, 5, 1'b0);

        txn(2'b01, 5, 0, 2, 1'b0);   // three up steps, done at cycle 8
        txn(2'b10, 0, 4, 4, 1'b0);   // equal value, done at cycle 2
        txn(2'b01, 6, 1, 1, 1'b1);   // target change and req drop mid-service
        txn(2'b01, 6, 0, 1, 1'b0);   // wrap scenario
        txn(2'b01, 4, 0, 0, 1'b0);   // tie scenario

        for (int i = 0; i < 40; i++) begin
            txn(2'($urandom_range(1, 3)),
                int'($urandom_range(0, M - 1)),
                int'($urandom_range(0, M - 1)),
                int'($urandom_range(0, M - 1)),
                ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
